// File: rtl/wait_state_data_mem.sv
// Word-addressed RAM responder for the multicycle CPU bus: answers each read/write
// request after LATENCY cycles with a one-cycle ready strobe and flags bad accesses.
module wait_state_data_mem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adrs,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  state_t                  state, next_state;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [31:0]             lat_adrs, lat_data;
  logic                    lat_wr, lat_perr;
  logic                    capture, capture_perr;
  logic                    bad_adrs, acc_err;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             ram [0:DEPTH-1];

  assign idx      = lat_adrs[DEPTH_LOG2+1:2];
  assign bad_adrs = (lat_adrs[1:0] != 2'b00) || (lat_adrs[31:DEPTH_LOG2+2] != '0);
  assign acc_err  = lat_perr || bad_adrs;

  // Next-state and wait-counter logic
  always_comb begin
    next_state   = state;
    cnt_nxt      = cnt;
    capture      = 1'b0;
    capture_perr = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read && mem_write) begin
          capture_perr = 1'b1;
          next_state   = RESP;
        end else if (mem_read || mem_write) begin
          capture    = 1'b1;
          cnt_nxt    = CW'(LATENCY - 1);
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) next_state = RESP;
      end
      RESP: next_state = DRAIN;
      DRAIN: begin
        if (!mem_read && !mem_write) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, request latches and registered response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_adrs <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      lat_perr <= 1'b0;
      data_out <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
      if (capture) begin
        lat_adrs <= adrs;
        lat_data <= data_in;
        lat_wr   <= mem_write;
        lat_perr <= 1'b0;
      end else if (capture_perr) begin
        lat_perr <= 1'b1;
      end
      ready <= (state == RESP);
      err   <= (state == RESP) && acc_err;
      if (state == RESP) begin
        if (acc_err)      data_out <= '0;
        else if (!lat_wr) data_out <= ram[idx];
      end
    end
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (rst && (state == RESP) && lat_wr && !acc_err) ram[idx] <= lat_data;
  end

endmodule
